// File: rtl/sync_hs_pkg.sv
// rtl/sync_hs_pkg.sv - shared types and parameter checks for the word handshake synchronizer
package sync_hs_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } srcState_e;

    localparam int SYNC_STAGES_MIN = 2;

    function automatic bit paramsOk(input int width, input int stages);
        return (width >= 1) && (stages >= SYNC_STAGES_MIN);
    endfunction

endpackage

// File: rtl/sync_toggle_chain.sv
// rtl/sync_toggle_chain.sv - N-flop single-bit synchronizer with optional negedge first stage
module sync_toggle_chain #(
    parameter int STAGES        = 2,
    parameter bit FIRST_NEGEDGE = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] syncFf;

    generate
        if (FIRST_NEGEDGE) begin : gFirstNeg
            // Half-cycle head start on the request; later stages restore posedge timing.
            always_ff @(negedge clk or negedge rstN) begin
                if (!rstN) syncFf[0] <= 1'b0;
                else       syncFf[0] <= d;
            end
        end else begin : gFirstPos
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) syncFf[0] <= 1'b0;
                else       syncFf[0] <= d;
            end
        end

        if (STAGES > 1) begin : gTail
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) syncFf[STAGES-1:1] <= '0;
                else       syncFf[STAGES-1:1] <= syncFf[STAGES-2:0];
            end
        end
    endgenerate

    assign q = syncFf[STAGES-1];

endmodule

// File: rtl/sync_word_handshake.sv
// rtl/sync_word_handshake.sv - toggle req/ack word crossing sCLK->dCLK; SYNC_WORD_HS_DEST_NEGEDGE_EN selects negedge first dest sync flop
module sync_word_handshake
    import sync_hs_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}}
) (
    input  logic             sCLK,
    input  logic             sRST_N,
    input  logic             dCLK,
    input  logic             sEN,
    input  logic [WIDTH-1:0] sD_IN,
    output logic             sRDY,
    output logic [WIDTH-1:0] dD_OUT,
    output logic             dVALID
);

    generate
        if (!paramsOk(WIDTH, SYNC_STAGES)) begin : gBadParams
            $error("sync_word_handshake: WIDTH must be >=1 and SYNC_STAGES >= SYNC_STAGES_MIN");
        end
    endgenerate

`ifdef SYNC_WORD_HS_DEST_NEGEDGE_EN
    localparam bit DEST_FIRST_NEG = 1'b1;
`else
    localparam bit DEST_FIRST_NEG = 1'b0;
`endif

    srcState_e        sState;
    logic [WIDTH-1:0] sDataReg;
    logic             sReqTgl;
    logic             sAckSync;
    logic             dReqSync;
    logic             dAckTgl;

    // sDataReg only moves on acceptance, so it is stable whenever dCLK samples it.
    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            sState   <= S_IDLE;
            sDataReg <= INIT;
            sReqTgl  <= 1'b0;
            sRDY     <= 1'b1;
        end else begin
            case (sState)
                S_IDLE: begin
                    if (sEN) begin
                        sDataReg <= sD_IN;
                        sReqTgl  <= ~sReqTgl;
                        sRDY     <= 1'b0;
                        sState   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (sAckSync == sReqTgl) begin
                        sRDY   <= 1'b1;
                        sState <= S_IDLE;
                    end
                end
                default: begin
                    sRDY   <= 1'b1;
                    sState <= S_IDLE;
                end
            endcase
        end
    end

    sync_toggle_chain #(
        .STAGES        (SYNC_STAGES),
        .FIRST_NEGEDGE (DEST_FIRST_NEG)
    ) uReqSync (
        .clk  (dCLK),
        .rstN (sRST_N),
        .d    (sReqTgl),
        .q    (dReqSync)
    );

    always_ff @(posedge dCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            dAckTgl <= 1'b0;
            dD_OUT  <= INIT;
            dVALID  <= 1'b0;
        end else if (dReqSync != dAckTgl) begin
            dD_OUT  <= sDataReg;
            dVALID  <= 1'b1;
            dAckTgl <= dReqSync;
        end else begin
            dVALID  <= 1'b0;
        end
    end

    sync_toggle_chain #(
        .STAGES        (SYNC_STAGES),
        .FIRST_NEGEDGE (1'b0)
    ) uAckSync (
        .clk  (sCLK),
        .rstN (sRST_N),
        .d    (dAckTgl),
        .q    (sAckSync)
    );

endmodule

// File: tb/tb_sync_word_handshake.sv
// tb/tb_sync_word_handshake.sv - scoreboard bench for sync_word_handshake
`timescale 1ns/100ps
module tb_sync_word_handshake;

    logic       sCLK = 1'b0;
    logic       dCLK = 1'b0;
    logic       sRST_N = 1'b0;
    logic       sEN = 1'b0;
    logic [7:0] sD_IN = 8'h00;
    logic       sRDY;
    logic [7:0] dD_OUT;
    logic       dVALID;

    real        dHalf = 8.5;
    int         nCmp = 0;
    int         nErr = 0;
    logic [7:0] sbQ[$];
    logic       prevValid = 1'b0;

    sync_word_handshake #(.WIDTH(8), .SYNC_STAGES(2), .INIT(8'h00)) dut (
        .sCLK   (sCLK),
        .sRST_N (sRST_N),
        .dCLK   (dCLK),
        .sEN    (sEN),
        .sD_IN  (sD_IN),
        .sRDY   (sRDY),
        .dD_OUT (dD_OUT),
        .dVALID (dVALID)
    );

    always #5 sCLK = ~sCLK;
    always #(dHalf) dCLK = ~dCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sample away from the active dCLK edge.
    always @(negedge dCLK) begin
        if (dVALID === 1'b1) begin
            chk("valid_not_consecutive", {31'd0, prevValid}, 32'd0);
            if (sbQ.size() == 0) begin
                chk("unexpected_dvalid", {24'd0, dD_OUT}, 32'hFFFF_FFFF);
            end else begin
                chk("delivered_word", {24'd0, dD_OUT}, {24'd0, sbQ.pop_front()});
            end
        end
        prevValid = (dVALID === 1'b1);
    end

    task automatic waitRdy(input string tag);
        int n = 0;
        while (sRDY !== 1'b1 && n < 2000) begin
            @(negedge sCLK);
            n++;
        end
        if (n >= 2000) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic sendWord(input logic [7:0] w);
        @(negedge sCLK);
        waitRdy("send_wait_rdy_timeout");
        sEN   = 1'b1;
        sD_IN = w;
        sbQ.push_back(w);
        @(negedge sCLK);
        sEN = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sbQ.size() != 0 || sRDY !== 1'b1) && n < 5000) begin
            @(negedge sCLK);
            n++;
        end
        chk(tag, sbQ.size(), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        #23;
        chk("reset_srdy", {31'd0, sRDY}, 32'd1);
        chk("reset_dvalid", {31'd0, dVALID}, 32'd0);
        chk("reset_dout", {24'd0, dD_OUT}, 32'h00);
        @(negedge sCLK);
        sRST_N = 1'b1;

        // Single transfer with latency bounds
        sendWord(8'hA5);
        chk("single_srdy_low", {31'd0, sRDY}, 32'd0);
        n = 0;
        while (dVALID !== 1'b1 && n < 20) begin
            @(negedge dCLK);
            n++;
        end
        chk("single_dvalid_within_4", {31'd0, (n <= 4)}, 32'd1);
        n = 0;
        while (sRDY !== 1'b1 && n < 20) begin
            @(negedge sCLK);
            n++;
        end
        chk("single_srdy_return", {31'd0, (n <= 6)}, 32'd1);
        drain("single_drain");
        chk("single_dout_hold", {24'd0, dD_OUT}, 32'hA5);

        // Back-to-back with sEN held; stray data presented while busy
        @(negedge sCLK);
        for (int i = 1; i <= 3; i++) begin
            waitRdy("b2b_wait_timeout");
            sEN   = 1'b1;
            sD_IN = i[7:0];
            sbQ.push_back(i[7:0]);
            @(negedge sCLK);
            sD_IN = 8'hEE;
        end
        sEN = 1'b0;
        drain("b2b_drain");

        // Ignored enable while busy
        sendWord(8'h77);
        for (int i = 0; i < 4; i++) begin
            sEN   = (sRDY !== 1'b1) ? i[0] : 1'b0;
            sD_IN = 8'hFF;
            @(negedge sCLK);
        end
        sEN = 1'b0;
        drain("ignored_en_drain");
        chk("ignored_en_dout", {24'd0, dD_OUT}, 32'h77);

        // Reset mid-transfer
        @(negedge sCLK);
        waitRdy("midrst_wait_timeout");
        sEN   = 1'b1;
        sD_IN = 8'h3C;
        @(negedge sCLK);
        sEN    = 1'b0;
        sRST_N = 1'b0;
        repeat (12) @(negedge sCLK);
        chk("midrst_dout_init", {24'd0, dD_OUT}, 32'h00);
        chk("midrst_dvalid_low", {31'd0, dVALID}, 32'd0);
        sRST_N = 1'b1;
        @(negedge sCLK);
        chk("midrst_srdy_high", {31'd0, sRDY}, 32'd1);
        sendWord(8'h5A);
        drain("midrst_next_drain");
        chk("midrst_next_dout", {24'd0, dD_OUT}, 32'h5A);

        // Fast destination clock, random words
        dHalf = 1.5;
        repeat (4) @(negedge sCLK);
        for (int i = 0; i < 200; i++) sendWord(8'($urandom_range(0, 255)));
        drain("fast_drain");

        // Slow destination clock, random words
        dHalf = 48.5;
        repeat (4) @(negedge sCLK);
        for (int i = 0; i < 200; i++) sendWord(8'($urandom_range(0, 255)));
        drain("slow_drain");

        repeat (4) @(negedge dCLK);
        chk("final_queue_empty", sbQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
